// File: rtl/user_ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port user RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface user_ram_arbiter_if #(
  parameter int unsigned ADDR_BIT = 8
);
  logic                a_req_i;
  logic                a_we_i;
  logic [ADDR_BIT-1:0] a_addr_i;
  logic [31:0]         a_wdata_i;
  logic                a_gnt_o;
  logic                a_rvalid_o;
  logic [31:0]         a_rdata_o;

  logic                b_req_i;
  logic                b_we_i;
  logic [ADDR_BIT-1:0] b_addr_i;
  logic [31:0]         b_wdata_i;
  logic                b_gnt_o;
  logic                b_rvalid_o;
  logic [31:0]         b_rdata_o;

  logic                ram_wr_en_o;
  logic                ram_rd_en_o;
  logic [ADDR_BIT-1:0] ram_addr_o;
  logic [31:0]         ram_di_o;
  logic [31:0]         ram_do_i;

  modport slave (
    input  a_req_i, a_we_i, a_addr_i, a_wdata_i,
    output a_gnt_o, a_rvalid_o, a_rdata_o,
    input  b_req_i, b_we_i, b_addr_i, b_wdata_i,
    output b_gnt_o, b_rvalid_o, b_rdata_o,
    output ram_wr_en_o, ram_rd_en_o, ram_addr_o, ram_di_o,
    input  ram_do_i
  );

  modport master (
    output a_req_i, a_we_i, a_addr_i, a_wdata_i,
    input  a_gnt_o, a_rvalid_o, a_rdata_o,
    output b_req_i, b_we_i, b_addr_i, b_wdata_i,
    input  b_gnt_o, b_rvalid_o, b_rdata_o,
    input  ram_wr_en_o, ram_rd_en_o, ram_addr_o, ram_di_o,
    output ram_do_i
  );
endinterface

// File: rtl/user_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (2-cycle read) between requesters A and B,
// with an INIT_VALUE write sweep over every address after reset and on clear_i.
module user_ram_arbiter #(
  parameter int unsigned ADDR_BIT      = 8,
  parameter logic [31:0] INIT_VALUE    = 32'h0,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  output logic              init_done_o,
  output logic              busy_o,
  user_ram_arbiter_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_BIT;
  localparam int unsigned CntW  = ADDR_BIT + 1;

  typedef enum logic [2:0] {StInit, StIdle, StWr, StRd1, StRd2} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_BIT-1:0] addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                owner_b_q, owner_b_d;
  logic                last_b_q, last_b_d;
  logic                clr_pend_q, clr_pend_d;
  logic                a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [31:0]         a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                pick_b;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= INIT_ON_RESET ? StInit : StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      owner_b_q  <= 1'b0;
      last_b_q   <= 1'b1;
      clr_pend_q <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      owner_b_q  <= owner_b_d;
      last_b_q   <= last_b_d;
      clr_pend_q <= clr_pend_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    owner_b_d  = owner_b_q;
    last_b_d   = last_b_q;
    clr_pend_d = clr_pend_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    // On a tie the side not granted last wins; a lone requester always wins.
    pick_b     = bus.b_req_i && (!bus.a_req_i || !last_b_q);

    // A clear during a transaction waits for it to finish; during the sweep it is dropped.
    if (clear_i && (state_q != StIdle) && (state_q != StInit)) clr_pend_d = 1'b1;

    case (state_q)
      StInit: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(Depth - 1)) state_d = StIdle;
      end
      StIdle: begin
        if (clr_pend_q || clear_i) begin
          state_d    = StInit;
          cnt_d      = '0;
          clr_pend_d = 1'b0;
        end else if (bus.a_req_i || bus.b_req_i) begin
          owner_b_d = pick_b;
          last_b_d  = pick_b;
          we_d      = pick_b ? bus.b_we_i    : bus.a_we_i;
          addr_d    = pick_b ? bus.b_addr_i  : bus.a_addr_i;
          wdata_d   = pick_b ? bus.b_wdata_i : bus.a_wdata_i;
          a_gnt_d   = !pick_b;
          b_gnt_d   = pick_b;
          state_d   = (pick_b ? bus.b_we_i : bus.a_we_i) ? StWr : StRd1;
        end
      end
      StWr:  state_d = StIdle;
      StRd1: state_d = StRd2;
      StRd2: begin
        state_d = StIdle;
        if (owner_b_q) begin
          b_rdata_d  = bus.ram_do_i;
          b_rvalid_d = 1'b1;
        end else begin
          a_rdata_d  = bus.ram_do_i;
          a_rvalid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // RAM controls come only from state and latched command registers.
  always_comb begin
    bus.ram_wr_en_o = 1'b0;
    bus.ram_rd_en_o = 1'b0;
    bus.ram_addr_o  = '0;
    bus.ram_di_o    = '0;
    case (state_q)
      StInit: begin
        bus.ram_wr_en_o = 1'b1;
        bus.ram_addr_o  = cnt_q[ADDR_BIT-1:0];
        bus.ram_di_o    = INIT_VALUE;
      end
      StWr: begin
        bus.ram_wr_en_o = 1'b1;
        bus.ram_addr_o  = addr_q;
        bus.ram_di_o    = wdata_q;
      end
      StRd1, StRd2: begin
        bus.ram_rd_en_o = 1'b1;
        bus.ram_addr_o  = addr_q;
      end
      default: ;
    endcase
  end

  assign init_done_o    = (state_q != StInit);
  assign busy_o         = (state_q != StIdle);
  assign bus.a_gnt_o    = a_gnt_q;
  assign bus.b_gnt_o    = b_gnt_q;
  assign bus.a_rvalid_o = a_rvalid_q;
  assign bus.b_rvalid_o = b_rvalid_q;
  assign bus.a_rdata_o  = a_rdata_q;
  assign bus.b_rdata_o  = b_rdata_q;

endmodule
